// File: rtl/simon_encrypt_ctrl.sv
// Iterative Simon block cipher core: one encryption round per clock, with the key
// schedule expanded on the fly alongside the data path.
module simon_encrypt_ctrl #(
  parameter int unsigned N = 16,
  parameter int unsigned M = 4,
  parameter int unsigned T = 32,
  parameter logic [61:0] Z = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_block,
  input  logic [M*N-1:0] in_key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_block,
  output logic           busy,
  output logic [4:0]     round_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d;
  logic [N-1:0]   k_q [M];
  logic [N-1:0]   k_d [M];
  logic [4:0]     round_q, round_d;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  logic [N-1:0] ks_tmp;
  logic [N-1:0] ks_new;
  logic         z_bit;

  // Z is written with symbol 0 on the left, i.e. in the MSB of the literal.
  always_comb begin
    z_bit  = Z[6'(61 - (int'(round_q) % 62))];
    ks_tmp = ror(k_q[M-1], 3) ^ k_q[1];
    ks_tmp = ks_tmp ^ ror(ks_tmp, 1);
    ks_new = ~k_q[0] ^ ks_tmp ^ {{(N-1){1'b0}}, z_bit} ^ {{(N-2){1'b0}}, 2'b11};
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    round_d = round_q;
    for (int i = 0; i < M; i++) k_d[i] = k_q[i];

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_block[2*N-1:N];
          y_d     = in_block[N-1:0];
          for (int i = 0; i < M; i++) k_d[i] = in_key[i*N +: N];
          round_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d = y_q ^ (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2) ^ k_q[0];
        y_d = x_q;
        for (int i = 0; i < M - 1; i++) k_d[i] = k_q[i+1];
        k_d[M-1] = ks_new;
        if (round_q == 5'(T - 1)) begin
          round_d = '0;
          state_d = StDone;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      round_q <= '0;
      for (int i = 0; i < M; i++) k_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      round_q <= round_d;
      for (int i = 0; i < M; i++) k_q[i] <= k_d[i];
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign round_idx = round_q;
  assign out_block = {x_q, y_q};

endmodule

// File: tb/tb_simon_encrypt_ctrl.sv
// Scoreboard bench for simon_encrypt_ctrl using the Simon32/64 known-answer vector.
module tb_simon_encrypt_ctrl;

  localparam logic [63:0] KatKey = 64'h1918111009080100;
  localparam logic [31:0] KatPt  = 32'h65656877;
  localparam logic [31:0] KatCt  = 32'hc69be9bb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_block;
  logic        busy;
  logic [4:0]  round_idx;

  simon_encrypt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: pops expected results on handshakes and tracks latency / round sequencing.
  logic prev_valid = 1'b0, prev_busy = 1'b0, prev_hs = 1'b0;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
      prev_hs    = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (prev_hs) chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
      if (busy) begin
        chk("round_idx", 64'(round_idx), 64'(busy_cnt));
        busy_cnt++;
      end else if (prev_busy) begin
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        busy_cnt = 0;
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail_now("output_without_accept");
        else chk("latency", 64'(cyc - acc_q.pop_front() - 1), 64'd32);
      end
      if (out_valid) begin
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else begin
          chk("out_block", 64'(out_block), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
      prev_valid = out_valid;
      prev_busy  = busy;
      prev_hs    = out_valid && out_ready;
    end
  end

  // inj_round/rst_round < 0 disables the respective disturbance.
  task automatic run_job(input logic [31:0] blk, input logic [63:0] key, input logic [31:0] ct,
                         input int stall, input int inj_round, input int rst_round,
                         input bit keep_valid);
    int n;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_block = blk;
    in_key   = key;
    exp_q.push_back(ct);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("accept_wait");
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;

    if (inj_round >= 0) begin
      n = 0;
      while (!(busy && round_idx == 5'(inj_round)) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) fail_now("inject_wait");
      in_valid = 1'b1;
      in_block = 32'h12345678;
      in_key   = 64'hdeadbeefcafef00d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end

    if (rst_round >= 0) begin
      n = 0;
      while (!(busy && round_idx == 5'(rst_round)) && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) fail_now("reset_wait");
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_round_idx", 64'(round_idx), 64'd0);
      chk("abort_out_block", 64'(out_block), 64'd0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_release", 64'(in_ready), 64'd1);
      return;
    end

    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("out_valid_wait");
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_round_idx", 64'(round_idx), 64'd0);
    chk("reset_out_block", 64'(out_block), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    run_job(KatPt, KatKey, KatCt, 0, -1, -1, 1'b0);   // known answer
    run_job(KatPt, KatKey, KatCt, 10, -1, -1, 1'b0);  // consumer stall
    run_job(KatPt, KatKey, KatCt, 0, 5, -1, 1'b0);    // ignored input mid-run
    run_job(KatPt, KatKey, KatCt, 0, -1, 17, 1'b0);   // mid-run reset, aborted
    run_job(KatPt, KatKey, KatCt, 0, -1, -1, 1'b0);   // job after reset
    run_job(KatPt, KatKey, KatCt, 0, -1, -1, 1'b1);   // back-to-back, first
    run_job(KatPt, KatKey, KatCt, 0, -1, -1, 1'b0);   // back-to-back, second

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) fail_now("results_outstanding");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
